// File: rtl/jfetch_bytecode_unit.sv
// Bytecode prefetch unit: fetches 16-bit code words into a byte FIFO and serves opcode/operand bytes.
// Optional macro JFETCH_REL_BRANCH_EN adds a relative-branch redirect (op_base + branch_ofs).
module jfetch_bytecode_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        sysreset,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    input  logic        jpc_load,
    input  logic [15:0] jpc_load_data,
    input  logic        op_pop,
    input  logic        op_pop2,
    input  logic        op_start,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic [15:0] jpc,
    output logic [15:0] op_base,
    output logic        underflow
`ifdef JFETCH_REL_BRANCH_EN
    ,
    input  logic        branch_rel,
    input  logic [15:0] branch_ofs
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               mem_rd_r;
    logic [15:0]        fetch_addr_r;
    logic [15:0]        jpc_r;
    logic [15:0]        op_base_r;
    logic               underflow_r;
    logic [7:0]         fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               load_s;
    logic [15:0]        load_addr_s;
    logic [1:0]         pop_want_s;
    logic               pop_ok_s;
    logic               pop_bad_s;
    logic [1:0]         pop_n_s;
    logic               push_s;
    logic [1:0]         push_n_s;
    logic [PTR_W-1:0]   wr_nxt1_s;
    logic [PTR_W-1:0]   rd_nxt1_s;

`ifdef JFETCH_REL_BRANCH_EN
    // An explicit load outranks a relative branch arriving in the same cycle.
    assign load_s      = jpc_load | branch_rel;
    assign load_addr_s = jpc_load ? jpc_load_data : (op_base_r + branch_ofs);
`else
    assign load_s      = jpc_load;
    assign load_addr_s = jpc_load_data;
`endif

    assign wr_nxt1_s  = wr_ptr_r + PTR_W'(1);
    assign rd_nxt1_s  = rd_ptr_r + PTR_W'(1);

    assign mem_addr   = fetch_addr_r[15:1];
    assign mem_rd     = mem_rd_r;
    assign jpc        = jpc_r;
    assign op_base    = op_base_r;
    assign underflow  = underflow_r;
    assign byte_valid = (count_r != CNT_W'(0));
    assign word_valid = (count_r >= CNT_W'(2));
    assign byte_out   = fifo_mem_r[rd_ptr_r];
    assign word_out   = {fifo_mem_r[rd_ptr_r], fifo_mem_r[rd_nxt1_s]};

    // Pop/push qualification; a redirect suppresses both and never flags underflow.
    always_comb begin
        pop_want_s = 2'd0;
        if (op_pop2) begin
            pop_want_s = 2'd2;
        end else if (op_pop) begin
            pop_want_s = 2'd1;
        end else begin
            pop_want_s = 2'd0;
        end
        pop_ok_s  = !load_s && (pop_want_s != 2'd0) && (count_r >= CNT_W'(pop_want_s));
        pop_bad_s = !load_s && (pop_want_s != 2'd0) && (count_r <  CNT_W'(pop_want_s));
        pop_n_s   = pop_ok_s ? pop_want_s : 2'd0;
        push_s    = (state_r == ST_REQ) && mem_ready && !load_s;
        push_n_s  = push_s ? (fetch_addr_r[0] ? 2'd1 : 2'd2) : 2'd0;
    end

    // FSM state register.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a request is only issued with two free bytes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!load_s && (count_r <= CNT_W'(FIFO_DEPTH - 2))) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_nxt_s = ST_IDLE;
                end else if (load_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_FLUSH: begin
                if (mem_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output: read strobe stays up through FLUSH so the stale transfer completes.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            mem_rd_r <= 1'b0;
        end else begin
            mem_rd_r <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_FLUSH);
        end
    end

    // FIFO storage, pointers, program counters and the sticky underflow flag.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            fetch_addr_r <= 16'h0000;
            jpc_r        <= 16'h0000;
            op_base_r    <= 16'h0000;
            underflow_r  <= 1'b0;
        end else if (load_s) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            fetch_addr_r <= load_addr_s;
            jpc_r        <= load_addr_s;
            underflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                if (fetch_addr_r[0]) begin
                    fifo_mem_r[wr_ptr_r] <= mem_data[7:0];
                end else begin
                    fifo_mem_r[wr_ptr_r]  <= mem_data[15:8];
                    fifo_mem_r[wr_nxt1_s] <= mem_data[7:0];
                end
                wr_ptr_r     <= wr_ptr_r + PTR_W'(push_n_s);
                fetch_addr_r <= fetch_addr_r + 16'(push_n_s);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(pop_n_s);
                jpc_r    <= jpc_r + 16'(pop_n_s);
                if (op_start) begin
                    op_base_r <= jpc_r;
                end
            end
            if (pop_bad_s) begin
                underflow_r <= 1'b1;
            end
            count_r <= count_r + CNT_W'(push_n_s) - CNT_W'(pop_n_s);
        end
    end

endmodule

// File: tb/tb_jfetch_bytecode_unit.sv
// Scoreboard bench for jfetch_bytecode_unit: directed loads/pops against a behavioural code memory.
module tb_jfetch_bytecode_unit;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        jpc_load;
    logic [15:0] jpc_load_data;
    logic        op_pop, op_pop2, op_start;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [15:0] word_out;
    logic        word_valid;
    logic [15:0] jpc, op_base;
    logic        underflow;
    logic        redirect;
`ifdef JFETCH_REL_BRANCH_EN
    logic        branch_rel;
    logic [15:0] branch_ofs;
    assign redirect = jpc_load | branch_rel;
`else
    assign redirect = jpc_load;
`endif

    jfetch_bytecode_unit #(.FIFO_DEPTH(4)) dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .jpc_load(jpc_load), .jpc_load_data(jpc_load_data),
        .op_pop(op_pop), .op_pop2(op_pop2), .op_start(op_start),
        .byte_out(byte_out), .byte_valid(byte_valid),
        .word_out(word_out), .word_valid(word_valid),
        .jpc(jpc), .op_base(op_base), .underflow(underflow)
`ifdef JFETCH_REL_BRANCH_EN
        , .branch_rel(branch_rel), .branch_ofs(branch_ofs)
`endif
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic        is_word;
        logic [15:0] data;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   lat      = 1;
    int   mem_cnt  = 0;
    bit   mem_busy = 1'b0;
    logic [14:0] mem_lat_addr = 15'h0000;

    function automatic logic [15:0] mem_word(input logic [14:0] a);
        case (a)
            15'h0000: return 16'hC3D4;
            15'h0008: return 16'h1510;
            15'h0009: return 16'h2A3B;
            15'h000A: return 16'h4C5D;
            15'h0018: return 16'h9988;
            15'h0020: return 16'h6677;
            15'h7FFF: return 16'hA1B2;
            default:  return 16'hEEEE;
        endcase
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%04h required=0x%04h", name, act, req);
        end
    endtask

    // Code memory: latches the address when a request is first seen, answers after lat+1 cycles.
    always begin
        @(posedge sysclk);
        #1;
        if (sysreset) begin
            mem_ready = 1'b0;
            mem_busy  = 1'b0;
            mem_cnt   = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mem_busy  = 1'b0;
        end else if (mem_rd) begin
            if (!mem_busy) begin
                mem_busy     = 1'b1;
                mem_cnt      = 0;
                mem_lat_addr = mem_addr;
            end
            if (mem_cnt >= lat) begin
                mem_ready = 1'b1;
                mem_data  = mem_word(mem_lat_addr);
            end else begin
                mem_cnt++;
            end
        end
    end

    // Monitor: every accepted pop is checked against the oldest expected entry.
    always @(negedge sysclk) begin
        if (!sysreset && !redirect) begin
            if (op_pop2 && word_valid) begin
                consume(1'b1, word_out);
            end else if (op_pop && !op_pop2 && byte_valid) begin
                consume(1'b0, {8'h00, byte_out});
            end
        end
    end

    task automatic consume(input logic is_word, input logic [15:0] d);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected actual=0x%04h@0x%04h required=none", d, jpc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_word !== is_word || e.data !== d || e.pc !== jpc) begin
                failures++;
                $display("FAIL pop_data actual=%0d:0x%04h@0x%04h required=%0d:0x%04h@0x%04h",
                         is_word, d, jpc, e.is_word, e.data, e.pc);
            end
        end
    endtask

    task automatic do_pop(input logic two, input logic [15:0] d, input logic [15:0] pc,
                          input logic start);
        int n = 0;
        exp_q.push_back(exp_t'({two, d, pc}));
        while (!(two ? word_valid : byte_valid) && n < 50) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL pop_wait actual=timeout required=valid for 0x%04h", pc);
            void'(exp_q.pop_back());
        end else begin
            op_pop   = !two;
            op_pop2  = two;
            op_start = start;
            @(posedge sysclk);
            #1;
            op_pop   = 1'b0;
            op_pop2  = 1'b0;
            op_start = 1'b0;
        end
    endtask

    task automatic do_load(input logic [15:0] a);
        jpc_load      = 1'b1;
        jpc_load_data = a;
        @(posedge sysclk);
        #1;
        jpc_load = 1'b0;
    endtask

    task automatic wait_byte(output int n);
        n = 0;
        while (!byte_valid && n < 40) begin
            @(posedge sysclk);
            #1;
            n++;
        end
    endtask

    task automatic settle();
        repeat (15) @(posedge sysclk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sysreset = 1'b1; mem_ready = 1'b0; mem_data = 16'h0000;
        jpc_load = 1'b0; jpc_load_data = 16'h0000;
        op_pop = 1'b0; op_pop2 = 1'b0; op_start = 1'b0;
`ifdef JFETCH_REL_BRANCH_EN
        branch_rel = 1'b0; branch_ofs = 16'h0000;
`endif
        repeat (3) @(posedge sysclk);
        #1;
        check16("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        check16("rst_byte_valid", {15'd0, byte_valid}, 16'd0);
        check16("rst_word_valid", {15'd0, word_valid}, 16'd0);
        check16("rst_underflow", {15'd0, underflow}, 16'd0);
        check16("rst_jpc", jpc, 16'h0000);
        check16("rst_op_base", op_base, 16'h0000);
        sysreset = 1'b0;
        settle();

        // Aligned load: first byte three edges after the load edge.
        do_load(16'h0010);
        wait_byte(n);
        check16("load_latency", 16'(n), 16'd3);
        check16("aligned_byte_out", {8'h00, byte_out}, 16'h0015);
        check16("aligned_word_out", word_out, 16'h1510);
        check16("aligned_jpc", jpc, 16'h0010);
        do_pop(1'b1, 16'h1510, 16'h0010, 1'b0);
        do_pop(1'b0, 16'h002A, 16'h0012, 1'b0);
        do_pop(1'b0, 16'h003B, 16'h0013, 1'b0);
        do_pop(1'b1, 16'h4C5D, 16'h0014, 1'b0);

        // Odd load: high byte of word 8 discarded, fetch continues at word 9.
        settle();
        do_load(16'h0011);
        wait_byte(n);
        check16("odd_byte_out", {8'h00, byte_out}, 16'h0010);
        check16("odd_jpc", jpc, 16'h0011);
        do_pop(1'b0, 16'h0010, 16'h0011, 1'b0);
        do_pop(1'b1, 16'h2A3B, 16'h0012, 1'b0);

        // Redirect during a stalled read: stale word 0x9988 must never appear.
        settle();
        lat = 5;
        do_load(16'h0030);
        n = 0;
        while (!(mem_rd && mem_addr == 15'h0018) && n < 20) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        repeat (2) @(posedge sysclk);
        #1;
        do_load(16'h0040);
        wait_byte(n);
        check16("flush_byte_out", {8'h00, byte_out}, 16'h0066);
        check16("flush_jpc", jpc, 16'h0040);
        do_pop(1'b1, 16'h6677, 16'h0040, 1'b1);
        check16("op_base_capture", op_base, 16'h0040);
        do_pop(1'b1, 16'hEEEE, 16'h0042, 1'b0);
`ifdef JFETCH_REL_BRANCH_EN
        branch_rel = 1'b1;
        branch_ofs = 16'hFFF0;
        @(posedge sysclk);
        #1;
        branch_rel = 1'b0;
        check16("branch_jpc", jpc, 16'h0030);
        check16("branch_op_base", op_base, 16'h0040);
`endif
        lat = 1;

        // op_pop2 with a single byte held: no effect except sticky underflow.
        settle();
        lat = 8;
        do_load(16'h0011);
        wait_byte(n);
        op_pop2 = 1'b1;
        @(posedge sysclk);
        #1;
        op_pop2 = 1'b0;
        check16("uflow_set", {15'd0, underflow}, 16'd1);
        check16("uflow_jpc", jpc, 16'h0011);
        check16("uflow_byte_out", {8'h00, byte_out}, 16'h0010);
        check16("uflow_word_valid", {15'd0, word_valid}, 16'd0);
        repeat (2) @(posedge sysclk);
        #1;
        check16("uflow_sticky", {15'd0, underflow}, 16'd1);
        lat = 1;
        do_load(16'h0010);
        check16("uflow_cleared", {15'd0, underflow}, 16'd0);

        // Load beats simultaneous pops on an empty FIFO.
        jpc_load = 1'b1; jpc_load_data = 16'h0011; op_pop = 1'b1; op_pop2 = 1'b1;
        @(posedge sysclk);
        #1;
        jpc_load = 1'b0; op_pop = 1'b0; op_pop2 = 1'b0;
        check16("load_pop_uflow", {15'd0, underflow}, 16'd0);
        check16("load_pop_jpc", jpc, 16'h0011);
        check16("load_pop_empty", {15'd0, byte_valid}, 16'd0);
        do_pop(1'b0, 16'h0010, 16'h0011, 1'b0);

        // 16-bit wrap of jpc and fetch address.
        settle();
        do_load(16'hFFFE);
        do_pop(1'b1, 16'hA1B2, 16'hFFFE, 1'b0);
        check16("wrap_jpc0", jpc, 16'h0000);
        do_pop(1'b0, 16'h00C3, 16'h0000, 1'b0);
        check16("wrap_jpc1", jpc, 16'h0001);

        repeat (2) @(posedge sysclk);
        #1;
        check16("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jfetch_bytecode_unit.md
JFETCH_BYTECODE_UNIT -- requirements
Module: jfetch_bytecode_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the bytecode prefetch FIFO capacity in bytes (power of 2, at least 4).
REQ-002 SHALL have port sysclk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port sysreset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port mem_addr, output, 15 bits: word address into code memory, equal to fetch_addr[15:1].
REQ-005 SHALL have port mem_rd, output, 1 bit: read request, held high until mem_ready is sampled high.
REQ-006 SHALL have ports mem_data (input, 16 bits: read word, high byte = even address) and mem_ready (input, 1 bit: mem_data valid this cycle).
REQ-007 SHALL have ports jpc_load (input, 1 bit: redirect strobe) and jpc_load_data (input, 16 bits: new byte address).
REQ-008 SHALL have ports op_pop (input, 1 bit: consume 1 byte), op_pop2 (input, 1 bit: consume 2 bytes) and op_start (input, 1 bit: the popped byte is an opcode).
REQ-009 SHALL have ports byte_out (output, 8 bits: FIFO head), byte_valid (output, 1 bit: at least 1 byte held), word_out (output, 16 bits: {head, head+1}, big-endian) and word_valid (output, 1 bit: at least 2 bytes held).
REQ-010 SHALL have ports jpc (output, 16 bits: address of head byte), op_base (output, 16 bits: address of last opcode popped with op_start) and underflow (output, 1 bit: sticky error flag).

Function
REQ-011 SHALL implement a state machine with states IDLE, REQ, and FLUSH.
REQ-012 IDLE SHALL go to REQ when free space is at least 2 bytes and no jpc_load is present.
REQ-013 REQ SHALL assert mem_rd, with mem_addr stable, until mem_ready is high.
REQ-014 On mem_ready in REQ, the unit SHALL push both bytes, high byte first, then advance fetch_addr by 2 and return to IDLE.
REQ-015 If fetch_addr is odd on mem_ready, the unit SHALL discard the high byte, push only the low byte, and advance fetch_addr by 1.
REQ-016 jpc_load SHALL clear the FIFO and set jpc and fetch_addr to jpc_load_data on the next edge.
REQ-017 If jpc_load arrives while a read is outstanding, the FSM SHALL enter FLUSH, drop the data returned on the next mem_ready, then go to IDLE.
REQ-018 jpc_load simultaneous with op_pop or op_pop2 SHALL win; the pop SHALL be ignored and SHALL NOT set underflow.
REQ-019 op_pop with byte_valid high SHALL remove 1 byte and set jpc to jpc+1 (16-bit wrap from 0xFFFF to 0x0000).
REQ-020 op_pop2 with word_valid high SHALL remove 2 bytes and set jpc to jpc+2, with the same wrap.
REQ-021 op_pop and op_pop2 asserted together SHALL act as op_pop2.
REQ-022 A pop without sufficient valid bytes SHALL leave the FIFO and jpc unchanged and set underflow; underflow SHALL clear only on jpc_load or reset.
REQ-023 op_start with a successful pop SHALL capture the pre-pop jpc into op_base.
REQ-024 A push and a pop in the same cycle SHALL both take effect, and the count SHALL equal old count + pushed − popped.
REQ-025 Latency: with mem_ready arriving 1 cycle after mem_rd, byte_valid SHALL rise 3 edges after the jpc_load edge.
REQ-026 byte_out and word_out SHALL be combinational from FIFO state; their contents are don't-care while the matching valid is low.
REQ-027 The FIFO SHALL never overflow; the unit SHALL request only when at least 2 bytes are free.

Reset
REQ-028 Under sysreset, the FSM SHALL go to IDLE and the FIFO count to 0.
REQ-029 Under sysreset, jpc, fetch_addr, and op_base SHALL be 0; mem_rd, byte_valid, word_valid, and underflow SHALL be 0.
REQ-030 Reset asserted while a read is outstanding SHALL abandon the read; any mem_ready after reset release SHALL be ignored unless it answers a new request.

Configuration
REQ-031 With macro JFETCH_REL_BRANCH_EN defined, the unit SHALL add ports branch_rel (input, 1 bit) and branch_ofs (input, 16 bits, signed).
REQ-032 With JFETCH_REL_BRANCH_EN defined, branch_rel SHALL act exactly as jpc_load with data op_base+branch_ofs (mod 2^16), including priority and FLUSH handling.
REQ-033 Without JFETCH_REL_BRANCH_EN, those ports SHALL be absent and relative branches SHALL be done by the MCU via jpc_load.

Verification
REQ-034 Load 0x0010 with memory word[8]=0x1510 and 1-cycle mem_ready -> byte_valid at edge+3; byte_out=0x15, word_out=0x1510, jpc=0x0010.
REQ-035 Load 0x0011 -> first byte_out is the low byte of word[8]; jpc=0x0011; fetch continues at word 9.
REQ-036 jpc_load during a 5-cycle stalled read -> the stale word is never visible; the FIFO holds only bytes from the new address.
REQ-037 op_pop2 with exactly 1 byte held -> FIFO and jpc unchanged, underflow=1; next jpc_load clears underflow.
REQ-038 Load 0xFFFE, pop 2 bytes, then pop 1 more -> jpc wraps to 0x0000, then reaches 0x0001.
REQ-039 With JFETCH_REL_BRANCH_EN: op_start pop at 0x0040, then branch_ofs=0xFFF0 -> jpc=0x0030, op_base=0x0040.
